inter_wb_master_bridge: RTL and testbench
=========================================

Name: inter_wb_master_bridge

Overview:
- Responder on one slave port of the read/write interconnect (req/gnt/rvalid protocol) that re-issues each accepted access as a Wishbone classic master cycle.
- Lets the cores, the Wishbone host and uart_to_mem reach external Wishbone peripherals through one interconnect slave slot.
- Carries one transaction at a time; has a bus timeout and a sticky error flag.

Parameters:
- DATA_WIDTH, 32, data width on both sides.
- ADDR_WIDTH, 11, byte-address width of the interconnect slave port.
- WB_ADDR_W, 32, Wishbone address width.
- BASE_ADDR, 32'h3000_0000, Wishbone base OR'ed with the word-aligned slave address.
- TIMEOUT, 255, maximum wait in cycles for ack/err while cyc is high; 8-bit counter.
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on error or timeout.

Ports:
- clk_i in 1: single clock.
- reset_ni in 1: asynchronous, active-low reset.
- slave_data_req_i in 1: request from the interconnect.
- slave_data_addr_i in ADDR_WIDTH: byte address.
- slave_data_we_i in 1: 1 = write.
- slave_data_be_i in DATA_WIDTH/8: byte enables.
- slave_data_wdata_i in DATA_WIDTH: write data.
- slave_data_gnt_o out 1: request accepted this cycle.
- slave_data_rvalid_o out 1: one-cycle response strobe, once per granted request.
- slave_data_rdata_o out DATA_WIDTH: read data, valid with rvalid.
- wbm_cyc_o out 1: Wishbone cycle.
- wbm_stb_o out 1: Wishbone strobe.
- wbm_we_o out 1: Wishbone write enable.
- wbm_sel_o out DATA_WIDTH/8: Wishbone byte selects.
- wbm_adr_o out WB_ADDR_W: Wishbone address.
- wbm_dat_o out DATA_WIDTH: Wishbone write data.
- wbm_dat_i in DATA_WIDTH: Wishbone read data.
- wbm_ack_i in 1: Wishbone acknowledge.
- wbm_err_i in 1: Wishbone error.
- bus_error_o out 1: sticky error or timeout flag.
- error_clr_i in 1: clears bus_error_o.

Behaviour:
- Reset (async, reset_ni=0):
  - Outputs: gnt, rvalid, cyc, stb, we and bus_error_o are 0; rdata, adr, dat_o and sel are 0.
  - State goes to IDLE and the timeout counter to 0.
  - Takes effect immediately, mid-cycle included. A Wishbone cycle in flight is abandoned and no rvalid is ever issued for it.
- State machine: IDLE -> BUS -> RESP -> IDLE.
- IDLE:
  - slave_data_gnt_o = slave_data_req_i (combinational, only in IDLE).
  - On a clock edge with req=1, capture:
    - we, be, wdata;
    - wbm_adr_o = BASE_ADDR | {addr[ADDR_WIDTH-1:2], 2'b00} (byte address zero-extended; low 2 bits forced to 0).
  - Then go to BUS.
- BUS:
  - cyc=stb=1; we, sel, adr and dat_o are held stable; gnt=0.
  - The counter increments every cycle in BUS.
  - Edge with ack_i=1: latch wbm_dat_i into rdata for reads; for writes rdata holds its previous value. Go to RESP; cyc and stb drop on that edge.
  - Edge with err_i=1 (priority over ack if both are high): rdata=ERR_DATA, set bus_error_o, go to RESP.
  - Edge where the counter equals TIMEOUT-1 with no ack/err: same as err (rdata=ERR_DATA, set bus_error_o, go to RESP).
- RESP:
  - slave_data_rvalid_o=1 for exactly one cycle, for reads and writes alike. gnt=0.
  - Next edge: go to IDLE, counter cleared.
- Latency:
  - Grant in cycle 0; cyc/stb high from cycle 1.
  - An ack sampled at the end of cycle N puts rvalid in cycle N+1.
  - With a zero-wait slave (ack in cycle 1), rvalid is in cycle 2; minimum 3 cycles per access.
  - Back-to-back: a request held high is granted again in the cycle after RESP.
- Requests during BUS/RESP are not granted. The requester holds req until gnt, per the interconnect rule.
- Stray ack/err in IDLE or RESP is ignored.
- bus_error_o:
  - Set on error or timeout; cleared by error_clr_i=1 at an edge.
  - If set and clear coincide, set wins.

Test Plan:
1. Read, zero-wait: req, addr=11'h104, we=0 -> gnt in cycle 0. Cycle 1: cyc=stb=1, adr=32'h3000_0104, we=0. Slave acks in cycle 1 with dat=32'hCAFE_0001 -> rvalid=1 in cycle 2 with rdata=32'hCAFE_0001; IDLE in cycle 3.
2. Write with wait states: addr=11'h00B, be=4'b0011, wdata=32'h1234_5678; ack after 3 wait cycles. Expect:
   - adr=32'h3000_0008, sel=4'b0011, dat_o=32'h1234_5678, we=1, all stable until ack;
   - a single rvalid pulse, with bus_error_o=0.
3. Timeout: TIMEOUT=8, slave never responds -> cyc drops after 8 BUS cycles; rvalid pulse with rdata=32'hDEAD_BEEF; bus_error_o=1 until error_clr_i pulse; error_clr_i asserted together with a new error keeps bus_error_o=1.
4. err_i and ack_i asserted together on a read -> rdata=32'hDEAD_BEEF, bus_error_o=1, exactly one rvalid.
5. Back-to-back: req held high for two reads -> the second gnt comes in the cycle after the first rvalid; no gnt is asserted during BUS or RESP; two rvalid pulses total.
6. Reset mid-BUS: reset_ni=0 while cyc=1 -> cyc, stb and gnt go to 0 immediately, with no rvalid. After release, a new read completes normally with 3-cycle latency.

Source files
------------

// File: rtl/inter_wb_master_bridge.sv
// Interconnect slave port (req/gnt/rvalid) to Wishbone classic master bridge.
// One access in flight at a time. Every granted request gets exactly one
// rvalid. A Wishbone error, or a slave that never answers, returns ERR_DATA
// and sets a sticky bus error flag.
module inter_wb_master_bridge #(
  parameter int unsigned                DATA_WIDTH = 32,
  parameter int unsigned                ADDR_WIDTH = 11,
  parameter int unsigned                WB_ADDR_W  = 32,
  parameter logic [WB_ADDR_W-1:0]       BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned                TIMEOUT    = 255,
  parameter logic [DATA_WIDTH-1:0]      ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    slave_data_req_i,
  input  logic [ADDR_WIDTH-1:0]   slave_data_addr_i,
  input  logic                    slave_data_we_i,
  input  logic [DATA_WIDTH/8-1:0] slave_data_be_i,
  input  logic [DATA_WIDTH-1:0]   slave_data_wdata_i,
  output logic                    slave_data_gnt_o,
  output logic                    slave_data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   slave_data_rdata_o,
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_we_o,
  output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
  output logic [WB_ADDR_W-1:0]    wbm_adr_o,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  input  logic                    wbm_ack_i,
  input  logic                    wbm_err_i,
  output logic                    bus_error_o,
  input  logic                    error_clr_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter value on the last BUS cycle that is still allowed to wait.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t                 state_q;
  state_t                 state_d;
  logic [7:0]             cnt_q;
  logic                   wb_fail;
  logic                   wb_done;
  logic [WB_ADDR_W-1:0]   adr_word;

  // Byte address zero-extended and forced to a word boundary before the base is merged in.
  assign adr_word = WB_ADDR_W'(slave_data_addr_i) & ~WB_ADDR_W'(3);

  // err takes priority over ack. A timeout counts only when the slave stays silent on the last allowed cycle.
  assign wb_fail = wbm_err_i || (!wbm_ack_i && (cnt_q == TO_LAST));
  assign wb_done = wbm_ack_i || wb_fail;

  // Next-state logic and the handshake strobes, all decoded from the current state.
  always_comb begin
    state_d             = state_q;
    slave_data_gnt_o    = 1'b0;
    slave_data_rvalid_o = 1'b0;
    wbm_cyc_o           = 1'b0;
    wbm_stb_o           = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Gated by reset so that no grant can appear while reset is asserted.
        slave_data_gnt_o = slave_data_req_i && reset_ni;
        if (slave_data_req_i) state_d = BUS;
      end
      BUS: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        if (wb_done) state_d = RESP;
      end
      RESP: begin
        slave_data_rvalid_o = 1'b1;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. Async reset abandons any Wishbone cycle in flight.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Capture the request attributes at grant and hold them for the whole Wishbone cycle.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else if (state_q == IDLE && slave_data_req_i) begin
      wbm_we_o  <= slave_data_we_i;
      wbm_sel_o <= slave_data_be_i;
      wbm_adr_o <= BASE_ADDR | adr_word;
      wbm_dat_o <= slave_data_wdata_i;
    end
  end

  // Response data: slave data on a read ack, ERR_DATA on error or timeout, otherwise held.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      slave_data_rdata_o <= '0;
    end else if (state_q == BUS) begin
      if (wb_fail)                     slave_data_rdata_o <= ERR_DATA;
      else if (wbm_ack_i && !wbm_we_o) slave_data_rdata_o <= wbm_dat_i;
    end
  end

  // Wait counter: counts BUS cycles and is cleared on the way back to IDLE.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)              cnt_q <= '0;
    else if (state_q == BUS)    cnt_q <= cnt_q + 8'd1;
    else if (state_q == RESP)   cnt_q <= '0;
  end

  // Sticky error flag. A new error wins over a clear in the same cycle.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)                      bus_error_o <= 1'b0;
    else if (state_q == BUS && wb_fail) bus_error_o <= 1'b1;
    else if (error_clr_i)               bus_error_o <= 1'b0;
  end

endmodule

// File: tb/tb_inter_wb_master_bridge.sv
// Directed bench for inter_wb_master_bridge with hand-computed expectations.
module tb_inter_wb_master_bridge;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        req;
  logic [10:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        cyc;
  logic        stb;
  logic        wbm_we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;
  logic        err;
  logic        bus_error;
  logic        clr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  inter_wb_master_bridge #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(11),
    .WB_ADDR_W (32),
    .BASE_ADDR (32'h3000_0000),
    .TIMEOUT   (8),
    .ERR_DATA  (32'hDEAD_BEEF)
  ) dut (
    .clk_i              (clk),
    .reset_ni           (reset_ni),
    .slave_data_req_i   (req),
    .slave_data_addr_i  (addr),
    .slave_data_we_i    (we),
    .slave_data_be_i    (be),
    .slave_data_wdata_i (wdata),
    .slave_data_gnt_o   (gnt),
    .slave_data_rvalid_o(rvalid),
    .slave_data_rdata_o (rdata),
    .wbm_cyc_o          (cyc),
    .wbm_stb_o          (stb),
    .wbm_we_o           (wbm_we),
    .wbm_sel_o          (sel),
    .wbm_adr_o          (adr),
    .wbm_dat_o          (dat_o),
    .wbm_dat_i          (dat_i),
    .wbm_ack_i          (ack),
    .wbm_err_i          (err),
    .bus_error_o        (bus_error),
    .error_clr_i        (clr)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Move to the next cycle: 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after inputs change.
  task automatic settle();
    #1;
  endtask

  task automatic drive_req(input logic [10:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
    req = 1'b1; addr = a; we = w; be = b; wdata = d;
  endtask

  initial begin
    reset_ni = 1'b0; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0;
    dat_i = '0; ack = 1'b0; err = 1'b0; clr = 1'b0;

    // ---- reset state ----
    step(); step();
    check_val("rst_gnt",    {63'd0, gnt},    64'd0);
    check_val("rst_rvalid", {63'd0, rvalid}, 64'd0);
    check_val("rst_cyc",    {63'd0, cyc},    64'd0);
    check_val("rst_stb",    {63'd0, stb},    64'd0);
    check_val("rst_we",     {63'd0, wbm_we}, 64'd0);
    check_val("rst_berr",   {63'd0, bus_error}, 64'd0);
    check_val("rst_rdata",  {32'd0, rdata},  64'd0);
    check_val("rst_adr",    {32'd0, adr},    64'd0);
    check_val("rst_dat_o",  {32'd0, dat_o},  64'd0);
    check_val("rst_sel",    {60'd0, sel},    64'd0);
    reset_ni = 1'b1;
    step();

    // ---- 1: zero-wait read ----
    drive_req(11'h104, 1'b0, 4'hF, 32'h0); settle();
    check_val("t1_gnt_c0", {63'd0, gnt}, 64'd1);
    step();
    req = 1'b0; ack = 1'b1; dat_i = 32'hCAFE_0001; settle();
    check_val("t1_cyc_c1", {63'd0, cyc}, 64'd1);
    check_val("t1_stb_c1", {63'd0, stb}, 64'd1);
    check_val("t1_adr_c1", {32'd0, adr}, {32'd0, 32'h3000_0104});
    check_val("t1_we_c1",  {63'd0, wbm_we}, 64'd0);
    check_val("t1_rv_c1",  {63'd0, rvalid}, 64'd0);
    step();
    ack = 1'b0; settle();
    check_val("t1_rv_c2",    {63'd0, rvalid}, 64'd1);
    check_val("t1_rdata_c2", {32'd0, rdata}, {32'd0, 32'hCAFE_0001});
    check_val("t1_cyc_c2",   {63'd0, cyc}, 64'd0);
    step();
    check_val("t1_rv_c3",  {63'd0, rvalid}, 64'd0);
    check_val("t1_cyc_c3", {63'd0, cyc}, 64'd0);

    // ---- 2: write with 3 wait states ----
    drive_req(11'h00B, 1'b1, 4'b0011, 32'h1234_5678); settle();
    check_val("t2_gnt", {63'd0, gnt}, 64'd1);
    step();
    req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      ack = (k == 4); settle();
      check_val("t2_cyc",   {63'd0, cyc}, 64'd1);
      check_val("t2_adr",   {32'd0, adr}, {32'd0, 32'h3000_0008});
      check_val("t2_sel",   {60'd0, sel}, {60'd0, 4'b0011});
      check_val("t2_dat_o", {32'd0, dat_o}, {32'd0, 32'h1234_5678});
      check_val("t2_we",    {63'd0, wbm_we}, 64'd1);
      check_val("t2_rv_wait", {63'd0, rvalid}, 64'd0);
      step();
    end
    ack = 1'b0; settle();
    check_val("t2_rv",      {63'd0, rvalid}, 64'd1);
    check_val("t2_berr",    {63'd0, bus_error}, 64'd0);
    check_val("t2_rdata_hold", {32'd0, rdata}, {32'd0, 32'hCAFE_0001});
    step();
    check_val("t2_rv_once", {63'd0, rvalid}, 64'd0);

    // ---- 3: timeout after 8 BUS cycles, sticky flag, clear ----
    drive_req(11'h010, 1'b0, 4'hF, 32'h0); settle();
    check_val("t3_gnt", {63'd0, gnt}, 64'd1);
    step();
    req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      settle();
      check_val("t3_cyc_wait", {63'd0, cyc}, 64'd1);
      check_val("t3_rv_wait",  {63'd0, rvalid}, 64'd0);
      step();
    end
    check_val("t3_cyc_drop", {63'd0, cyc}, 64'd0);
    check_val("t3_rv",       {63'd0, rvalid}, 64'd1);
    check_val("t3_rdata",    {32'd0, rdata}, {32'd0, 32'hDEAD_BEEF});
    check_val("t3_berr",     {63'd0, bus_error}, 64'd1);
    step(); step();
    check_val("t3_berr_sticky", {63'd0, bus_error}, 64'd1);
    clr = 1'b1; step(); clr = 1'b0;
    check_val("t3_berr_clr", {63'd0, bus_error}, 64'd0);
    // Second timeout with clear held across the failing edge: set must win.
    drive_req(11'h014, 1'b0, 4'hF, 32'h0); step();
    req = 1'b0;
    for (int k = 1; k <= 7; k++) step();
    clr = 1'b1; step(); clr = 1'b0;
    check_val("t3_set_wins", {63'd0, bus_error}, 64'd1);
    check_val("t3_rv2",      {63'd0, rvalid}, 64'd1);
    step();
    clr = 1'b1; step(); clr = 1'b0;
    check_val("t3_berr_clr2", {63'd0, bus_error}, 64'd0);

    // ---- 4: err and ack together on a read ----
    drive_req(11'h018, 1'b0, 4'hF, 32'h0); step();
    req = 1'b0; ack = 1'b1; err = 1'b1; dat_i = 32'h5555_5555; step();
    ack = 1'b0; err = 1'b0; settle();
    check_val("t4_rv",    {63'd0, rvalid}, 64'd1);
    check_val("t4_rdata", {32'd0, rdata}, {32'd0, 32'hDEAD_BEEF});
    check_val("t4_berr",  {63'd0, bus_error}, 64'd1);
    step();
    check_val("t4_rv_once", {63'd0, rvalid}, 64'd0);
    clr = 1'b1; step(); clr = 1'b0;

    // ---- 5: back-to-back reads with req held ----
    drive_req(11'h020, 1'b0, 4'hF, 32'h0); settle();
    check_val("t5_gnt_a", {63'd0, gnt}, 64'd1);
    step();
    ack = 1'b1; dat_i = 32'hAAAA_0001; settle();
    check_val("t5_no_gnt_bus", {63'd0, gnt}, 64'd0);
    check_val("t5_cyc_a",      {63'd0, cyc}, 64'd1);
    step();
    ack = 1'b0; addr = 11'h024; settle();
    check_val("t5_no_gnt_resp", {63'd0, gnt}, 64'd0);
    check_val("t5_rv_a",        {63'd0, rvalid}, 64'd1);
    check_val("t5_rdata_a",     {32'd0, rdata}, {32'd0, 32'hAAAA_0001});
    step();
    check_val("t5_gnt_b", {63'd0, gnt}, 64'd1);
    check_val("t5_rv_gap", {63'd0, rvalid}, 64'd0);
    step();
    req = 1'b0; ack = 1'b1; dat_i = 32'hBBBB_0002; settle();
    check_val("t5_adr_b", {32'd0, adr}, {32'd0, 32'h3000_0024});
    step();
    ack = 1'b0; settle();
    check_val("t5_rv_b",    {63'd0, rvalid}, 64'd1);
    check_val("t5_rdata_b", {32'd0, rdata}, {32'd0, 32'hBBBB_0002});
    step();

    // ---- 6: reset in the middle of a BUS cycle ----
    drive_req(11'h030, 1'b0, 4'hF, 32'h0); step();
    settle();
    check_val("t6_cyc_pre", {63'd0, cyc}, 64'd1);
    req = 1'b1; reset_ni = 1'b0; settle();
    check_val("t6_cyc_rst", {63'd0, cyc}, 64'd0);
    check_val("t6_stb_rst", {63'd0, stb}, 64'd0);
    check_val("t6_gnt_rst", {63'd0, gnt}, 64'd0);
    req = 1'b0;
    step();
    check_val("t6_rv_rst", {63'd0, rvalid}, 64'd0);
    reset_ni = 1'b1;
    step();
    check_val("t6_rv_after", {63'd0, rvalid}, 64'd0);
    drive_req(11'h040, 1'b0, 4'hF, 32'h0); settle();
    check_val("t6_gnt_new", {63'd0, gnt}, 64'd1);
    step();
    req = 1'b0; ack = 1'b1; dat_i = 32'h0BAD_F00D; settle();
    check_val("t6_adr_new", {32'd0, adr}, {32'd0, 32'h3000_0040});
    step();
    ack = 1'b0; settle();
    check_val("t6_rv_new",    {63'd0, rvalid}, 64'd1);
    check_val("t6_rdata_new", {32'd0, rdata}, {32'd0, 32'h0BAD_F00D});
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
